// File: rtl/pwm_cfg_encoder.sv
// Averages one PWM metacycle of signed samples and encodes the rounded 12-bit
// code as the PWM configuration word {level[7:0], spread-thermometer[15:0]}.
module pwm_cfg_encoder #(
  parameter int DW       = 14,
  parameter int AVG_LOG2 = 12
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic signed [DW-1:0] dat_i,
  input  logic                 pwm_s_i,
  input  logic                 hold_i,
  input  logic                 err_clr_i,
  output logic [23:0]          cfg_o,
  output logic [11:0]          code_o,
  output logic                 win_err_o
);

  localparam int AW = DW + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int QW = DW - 1;
  localparam logic [CW-1:0] WIN_LEN = {1'b1, {AVG_LOG2{1'b0}}};
  localparam logic [AW:0]   RND     = {{(AW-AVG_LOG2-1){1'b0}}, 1'b1, {(AVG_LOG2+1){1'b0}}};

  logic [DW-1:0] u;
  logic [AW-1:0] acc, acc_next, sum_cap;
  logic [CW-1:0] cnt, cnt_next, cnt_cap;
  logic          primed, v1, v2;
  logic          win_ok;
  logic [AW:0]   rnd;
  logic [QW-1:0] q;
  logic [11:0]   code_rnd, code_s1;
  logic [23:0]   cfg_next;

  // Spread thermometer: fill positions in bit-reversed order so the ones are
  // spread evenly across the 16 sub-periods.
  function automatic logic [15:0] pat(input logic [3:0] n);
    logic [15:0] r;
    logic [3:0]  idx;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      idx  = 4'(i);
      r[i] = ({idx[0], idx[1], idx[2], idx[3]} < n);
    end
    return r;
  endfunction

  assign u        = {~dat_i[DW-1], dat_i[DW-2:0]};
  assign acc_next = cnt[CW-1] ? acc : acc + AW'(u);
  assign cnt_next = (&cnt) ? cnt : cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc     <= '0;
      cnt     <= '0;
      sum_cap <= '0;
      cnt_cap <= '0;
      primed  <= 1'b0;
      v1      <= 1'b0;
    end else if (pwm_s_i) begin
      sum_cap <= acc_next;
      cnt_cap <= cnt_next;
      acc     <= '0;
      cnt     <= '0;
      primed  <= 1'b1;
      v1      <= primed;
    end else begin
      acc <= acc_next;
      cnt <= cnt_next;
      v1  <= 1'b0;
    end
  end

  // Round-half-up of the window mean of u, scaled from DW bits down to 12.
  assign win_ok   = (cnt_cap == WIN_LEN);
  assign rnd      = {1'b0, sum_cap} + RND;
  assign q        = rnd[AW:AVG_LOG2+2];
  assign code_rnd = (q > QW'(12'hFFF)) ? 12'hFFF : q[11:0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      v2        <= 1'b0;
      code_s1   <= '0;
      win_err_o <= 1'b0;
    end else begin
      v2        <= v1 && win_ok;
      if (v1 && win_ok)
        code_s1 <= code_rnd;
      win_err_o <= (v1 && !win_ok) || (win_err_o && !err_clr_i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      code_o   <= '0;
      cfg_next <= '0;
    end else if (v2) begin
      code_o   <= code_s1;
      cfg_next <= {code_s1[11:4], pat(code_s1[3:0])};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn)
      cfg_o <= '0;
    else if (pwm_s_i && !hold_i)
      cfg_o <= cfg_next;
  end

endmodule

// File: tb/tb_pwm_cfg_encoder.sv
// Bench for pwm_cfg_encoder: fixed vector table, reset/error corner sequences,
// and randomized windows checked against a window-level reference model.
module tb_pwm_cfg_encoder;

  localparam int N = 4096;

  logic               clk = 1'b0;
  logic               rstn;
  logic signed [13:0] dat;
  logic               pwm_s, hold, err_clr;
  logic [23:0]        cfg;
  logic [11:0]        code;
  logic               win_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pwm_cfg_encoder #(.DW(14), .AVG_LOG2(12)) dut (
    .clk(clk), .rstn(rstn), .dat_i(dat), .pwm_s_i(pwm_s), .hold_i(hold),
    .err_clr_i(err_clr), .cfg_o(cfg), .code_o(code), .win_err_o(win_err)
  );

  // Reference model state
  longint      m_sum;
  int          m_cnt;
  bit          m_primed, m_pend, m_err;
  logic [23:0] m_cfg, m_next;
  logic [11:0] m_code;

  int fill_order[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  function automatic logic [15:0] ref_pat(input int n);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[fill_order[k]] = 1'b1;
    return r;
  endfunction

  function automatic logic [11:0] ref_code(input longint s);
    longint c;
    c = (s + 2 * N) / (4 * N);
    if (c > 4095) c = 4095;
    return 12'(c);
  endfunction

  function automatic logic [23:0] ref_word(input logic [11:0] c);
    int ci;
    ci = int'(c);
    return {8'(ci / 16), ref_pat(ci % 16)};
  endfunction

  task automatic step(input int d, input bit p, input bit h, input bit clr, input bit rst_low);
    dat = 14'(d); pwm_s = p; hold = h; err_clr = clr; rstn = !rst_low;
    @(posedge clk);
    if (rst_low) begin
      m_sum = 0; m_cnt = 0; m_primed = 0; m_pend = 0; m_err = 0;
      m_cfg = '0; m_next = '0; m_code = '0;
    end else begin
      if (clr) m_err = 0;
      if (m_pend) m_err = 1;
      m_pend = 0;
      if (m_cnt < N) m_sum += longint'(d + 8192);
      m_cnt++;
      if (p) begin
        if (!h) m_cfg = m_next;
        if (m_primed) begin
          if (m_cnt == N) begin
            m_code = ref_code(m_sum);
            m_next = ref_word(m_code);
          end else begin
            m_pend = 1;
          end
        end
        m_primed = 1; m_sum = 0; m_cnt = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_window(input int len, input int dc, input bit rnd, input bit h,
                            input bit clr_mid, input int done);
    int d;
    for (int i = done + 1; i <= len; i++) begin
      d = rnd ? (int'($urandom_range(0, 16383)) - 8192) : dc;
      step(d, i == len, h, clr_mid && (i == 20), 1'b0);
    end
  endtask

  task automatic lead(input int dc, input bit rnd);
    for (int i = 0; i < 3; i++)
      step(rnd ? (int'($urandom_range(0, 16383)) - 8192) : dc, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_vs(input string name, input logic [23:0] ec, input logic [11:0] eco, input bit ee);
    vectors++;
    if (cfg !== ec || code !== eco || win_err !== ee) begin
      miscompares++;
      $display("FAIL %s: got cfg=%h code=%0d err=%b, expected cfg=%h code=%0d err=%b",
               name, cfg, code, win_err, ec, eco, ee);
    end
  endtask

  task automatic check_model(input string name);
    check_vs({name, "_model"}, m_cfg, m_code, m_err);
  endtask

  typedef struct {
    int          dat;
    bit          hold;
    bit          clr;
    int          len;
    logic [23:0] cfg;
    logic [11:0] code;
    bit          err;
  } vec_t;

  localparam int NT = 15;
  vec_t tab[NT];

  initial begin
    tab[0]  = '{-8192, 0, 0,   10, 24'h000000,    0, 0};
    tab[1]  = '{-8192, 0, 0, 4096, 24'h000000,    0, 0};
    tab[2]  = '{-8192, 0, 0, 4096, 24'h000000,    0, 0};
    tab[3]  = '{ 8191, 0, 0, 4096, 24'h000000, 4095, 0};
    tab[4]  = '{    0, 0, 0, 4096, 24'hFF7FFF, 2048, 0};
    tab[5]  = '{    5, 0, 0, 4096, 24'h800000, 2049, 0};
    tab[6]  = '{   32, 0, 0, 4096, 24'h800001, 2056, 0};
    tab[7]  = '{   16, 0, 0, 4096, 24'h805555, 2052, 0};
    tab[8]  = '{    0, 0, 0, 4000, 24'h801111, 2052, 1};
    tab[9]  = '{    0, 0, 0, 4200, 24'h801111, 2052, 1};
    tab[10] = '{    0, 0, 1, 4096, 24'h801111, 2048, 0};
    tab[11] = '{    0, 0, 0, 4096, 24'h800000, 2048, 0};
    tab[12] = '{   32, 1, 0, 4096, 24'h800000, 2056, 0};
    tab[13] = '{   32, 1, 0, 4096, 24'h800000, 2056, 0};
    tab[14] = '{    0, 0, 0, 4096, 24'h805555, 2048, 0};

    for (int i = 0; i < 3; i++) step(-8192, 1'b0, 1'b0, 1'b0, 1'b1);
    check_vs("reset", 24'h000000, 12'd0, 1'b0);
    check_model("reset");

    lead(tab[0].dat, 1'b0);
    for (int e = 0; e < NT; e++) begin
      int nxt;
      nxt = (e + 1 < NT) ? e + 1 : e;
      run_window(tab[e].len, tab[e].dat, 1'b0, tab[e].hold, tab[e].clr, 3);
      lead(tab[nxt].dat, 1'b0);
      check_vs($sformatf("tab%0d", e), tab[e].cfg, tab[e].code, tab[e].err);
      check_model($sformatf("tab%0d", e));
    end

    // Reset in the middle of a window, then re-prime
    for (int i = 0; i < 97; i++) step(16, 1'b0, 1'b0, 1'b0, 1'b0);
    step(16, 1'b0, 1'b0, 1'b0, 1'b1);
    check_vs("rst_mid", 24'h000000, 12'd0, 1'b0);
    lead(16, 1'b0);
    run_window(50, 16, 1'b0, 1'b0, 1'b0, 3);
    lead(16, 1'b0);
    check_vs("rst_prime", 24'h000000, 12'd0, 1'b0);
    run_window(N, 16, 1'b0, 1'b0, 1'b0, 3);
    lead(0, 1'b0);
    check_vs("rst_win1", 24'h000000, 12'd2052, 1'b0);
    run_window(N, 0, 1'b0, 1'b0, 1'b0, 3);
    lead(0, 1'b0);
    check_vs("rst_win2", 24'h801111, 12'd2048, 1'b0);
    check_model("rst_win2");

    // Short window: clear arrives in the same cycle the flag is set
    run_window(100, 0, 1'b0, 1'b0, 1'b0, 3);
    step(0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_vs("err_set_wins", 24'h800000, 12'd2048, 1'b1);
    step(0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_vs("err_clr", 24'h800000, 12'd2048, 1'b0);
    check_model("err_clr");

    // Randomized sample data, hold and clear against the model
    run_window(N, 0, 1'b1, 1'b0, 1'b0, 5);
    lead(0, 1'b1);
    check_model("rand_a");
    for (int r = 0; r < 4; r++) begin
      int len;
      bit h, c;
      len = (r < 2) ? N : int'($urandom_range(60, 300));
      h   = ($urandom_range(0, 3) == 0);
      c   = ($urandom_range(0, 1) == 1);
      run_window(len, 0, 1'b1, h, c, 3);
      lead(0, 1'b1);
      check_model($sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_cfg_encoder.md
Name: pwm_cfg_encoder

Overview:
Upstream feeder for the 24-bit dithered PWM stage (8-bit level plus 16-bit b-pattern, 16x256-cycle metacycle). It averages a signed DSP sample stream over exactly one PWM metacycle, aligned to the PWM's `pwm_s` sync pulse. It rounds the average to a 12-bit code and encodes it as the {level[7:0], spread-thermometer[15:0]} configuration word. The word is presented on `cfg_o` one cycle after `pwm_s`, which is the cycle in which the PWM latches it.

Parameters:
DW, 14, input sample width (signed two's complement).
AVG_LOG2, 12, log2 of samples per window; must equal log2(16*256) of the PWM metacycle.

Ports:
clk  in  1  clock.
rstn  in  1  reset; synchronous, active-low.
dat_i  in  DW  signed sample, one per clk.
pwm_s_i  in  1  PWM sync pulse, 1 cycle wide, once per metacycle.
hold_i  in  1  freeze `cfg_o` at its current value.
err_clr_i  in  1  clear `win_err_o`.
cfg_o  out  24  {level[7:0], pattern[15:0]} to PWM `cfg`.
code_o  out  12  last accepted 12-bit code (debug/readback).
win_err_o  out  1  sticky flag: a window length was not 2^AVG_LOG2.

Behaviour:
- Reset: `cfg_o`=0, `code_o`=0, `win_err_o`=0, accumulator=0, sample count=0, primed=0, staged word `cfg_next`=0, pipeline valid bits=0.
- Offset: u = dat_i + 2^(DW-1), unsigned DW bits (-8192 -> 0, +8191 -> 16383).
- Window definition: samples from the cycle after one `pwm_s_i` up to and including the cycle of the next `pwm_s_i`.
- Accumulator: width DW+AVG_LOG2. Adds u only while count < 2^AVG_LOG2; it never overflows.
- Count: width AVG_LOG2+1, saturating at all-ones.
- On `pwm_s_i` (edge T):
  - Capture sum_cap = acc + u (if count < 2^AVG_LOG2, else acc).
  - Capture cnt_cap = count+1 (saturating).
  - Reset acc and count to 0.
  - Set primed=1.
  - Launch pipeline stage 1 only if primed was already 1. The first pulse after reset only opens a window: no update, no error.
- Stage 1 (edge T+1):
  - If cnt_cap != 2^AVG_LOG2: set `win_err_o`; `cfg_next` and `code_o` are unchanged.
  - Else: code = (sum_cap + 2^(AVG_LOG2+1)) >> (AVG_LOG2+2), saturated to 4095.
- Stage 2 (edge T+2): `code_o` <= code. `cfg_next` <= {code[11:4], pat(code[3:0])}.
  - pat(n): bit i = 1 iff bitreverse4(i) < n.
  - Examples: pat(0)=0x0000, pat(1)=0x0001, pat(4)=0x1111, pat(8)=0x5555, pat(15)=0x7FFF.
- Output update: at every `pwm_s_i` edge, `cfg_o` <= `cfg_next` unless `hold_i`=1 (then `cfg_o` holds).
  - Latency: a window closed at pulse k reaches `cfg_o` at pulse k+1. The PWM uses it from the metacycle after that.
- Minimum spacing: windows shorter than 3 cycles are out of spec. Such a window is still flagged via cnt_cap, but `cfg_next` timing is not guaranteed.
- Error flag: `win_err_o` is sticky. `err_clr_i` clears it; a set and a clear in the same cycle result in set.
- Windows longer than 2^AVG_LOG2 cycles: samples beyond 2^AVG_LOG2 are ignored and the window is flagged.
- `hold_i` does not stop accumulation, `code_o` updates, or error detection.
- Reset mid-window: all state returns to reset values immediately. The next `pwm_s_i` only primes.

Test Plan:
1. Reset, `dat_i`=-8192, `pwm_s_i` every 4096 cycles -> after the 3rd pulse: `cfg_o`=24'h000000, `code_o`=0, `win_err_o`=0.
2. `dat_i`=+8191 constant -> code saturates to 4095, `cfg_o`=24'hFF7FFF; `dat_i`=0 -> `code_o`=2048, `cfg_o`=24'h800000.
3. `dat_i`=+5 -> code 2049, `cfg_o`=24'h800001; `dat_i`=+32 -> code 2056, `cfg_o`=24'h805555; `dat_i`=+16 -> code 2052, `cfg_o`=24'h801111.
4. One window of 4000 cycles, then one of 4200 -> `win_err_o`=1 after each, `cfg_o` keeps its prior value; pulse `err_clr_i` -> 0; a following 4096 window updates normally.
5. `hold_i`=1 across two pulses while the input changes 0 -> +32 -> `cfg_o` stays 24'h800000; `hold_i`=0 -> next pulse gives 24'h805555.
6. `rstn` low mid-window with `cfg_o`=24'h805555 -> `cfg_o`=0 next cycle. The first pulse after reset gives no update and no error; the second pulse's window appears at the third pulse.
